// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the dataMem arbiter: one-hot load/store instruction codes,
// the masks derived from them, and the FSM state encoding.
package dmem_arbiter_pkg;

  localparam logic [63:0] INST_LB  = 64'd1 << 11;
  localparam logic [63:0] INST_LH  = 64'd1 << 12;
  localparam logic [63:0] INST_LW  = 64'd1 << 13;
  localparam logic [63:0] INST_LBU = 64'd1 << 14;
  localparam logic [63:0] INST_LHU = 64'd1 << 15;
  localparam logic [63:0] INST_SB  = 64'd1 << 16;
  localparam logic [63:0] INST_SH  = 64'd1 << 17;
  localparam logic [63:0] INST_SW  = 64'd1 << 18;

  localparam logic [63:0] ST_MASK   = INST_SB | INST_SH | INST_SW;
  localparam logic [63:0] LS_MASK   = INST_LB | INST_LH | INST_LW | INST_LBU | INST_LHU | ST_MASK;
  localparam logic [63:0] HALF_MASK = INST_LH | INST_LHU | INST_SH;
  localparam logic [63:0] WORD_MASK = INST_LW | INST_SW;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // A well-formed instruction carries exactly one load/store bit and nothing else.
  function automatic logic inst_malformed(input logic [63:0] inst);
    return ($countones(inst & LS_MASK) != 1) || ((inst & ~LS_MASK) != 64'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant for the dataMem arbiter: round-robin by default, fixed priority
// to port 0 when DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, reset, i_accept};
  assign o_grant  = i_valid[0] ? 2'b01 : {i_valid[1], 1'b0};
`else
  // Last port granted; resets to 1 so port 0 wins the first tie.
  logic r_rr_last;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset)         r_rr_last <= 1'b1;
    else if (i_accept) r_rr_last <= o_grant[1];
  end

  always_comb begin
    // NOTE: default first so no path leaves o_grant unassigned (no latch).
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_rr_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for dataMem: grant, validate, issue for one cycle,
// wait MEM_LAT cycles for load data, respond. Grant policy set by DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = 4096,
  parameter int MEM_LAT  = 1,
  parameter int AW       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0][63:0]   req_inst,
  input  logic [1:0][AW-1:0] req_addr,
  input  logic [1:0][31:0]   req_wdata,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [63:0]        mem_inst,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam logic [AW-1:0] MEM_WORDS = AW'(MEM_SIZE);

  logic [2:0]    r_state;
  logic [63:0]   r_inst;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_port;
  logic [2:0]    r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic [1:0] w_grant;
  logic       w_idle;
  logic       w_xfer;
  logic       w_gnt_port;
  logic       w_misalign;
  logic       w_oob;
  logic       w_chk_err;
  logic       w_is_store;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_xfer     = w_idle && (w_grant != 2'b00);
  assign w_gnt_port = w_grant[1];

  dmem_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (req_valid),
    .i_accept (w_xfer),
    .o_grant  (w_grant)
  );

  assign w_misalign = (((r_inst & HALF_MASK) != 64'd0) && r_addr[0]) ||
                      (((r_inst & WORD_MASK) != 64'd0) && (r_addr[1:0] != 2'b00));
  assign w_oob      = (r_addr >> 2) >= MEM_WORDS;
  assign w_chk_err  = inst_malformed(r_inst) || w_misalign || w_oob;
  assign w_is_store = (r_inst & ST_MASK) != 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_inst  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_port  <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_inst  <= req_inst[w_gnt_port];
            r_addr  <= req_addr[w_gnt_port];
            r_wdata <= req_wdata[w_gnt_port];
            r_port  <= w_gnt_port;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_chk_err) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_is_store) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            // WAIT lasts MEM_LAT cycles; data is captured at the end of the last one.
            r_cnt   <= 3'(MEM_LAT - 1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rdata <= mem_rdata;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_port]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // dataMem sees a non-zero instruction only during ISSUE, so nothing stale can store.
  assign mem_inst  = (r_state == ST_ISSUE) ? r_inst : 64'd0;
  assign mem_addr  = 32'(r_addr);
  assign mem_wdata = r_wdata;

  assign req_ready = w_idle ? w_grant : 2'b00;
  assign rsp_valid = (r_state == ST_RESP) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dataMem and a response scoreboard.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MEM_SIZE = 256;
  localparam int MEM_LAT  = 3;
  localparam int AW       = 32;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][63:0]   req_inst;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][31:0]   req_wdata;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [63:0]        mem_inst;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   issue_cnt = 0;
  logic [63:0] last_inst;
  logic [31:0] last_addr;
  exp_t exp_q[$];
  int   grant_q[$];
  logic [31:0] mem [MEM_SIZE];
  logic [31:0] pipe [MEM_LAT];
  bit   t5_done;

  dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_inst(mem_inst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [63:0] inst, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * int'(off));
    case (inst)
      INST_LB:  return {{24{sh[7]}}, sh[7:0]};
      INST_LBU: return {24'h0, sh[7:0]};
      INST_LH:  return {{16{sh[15]}}, sh[15:0]};
      INST_LHU: return {16'h0, sh[15:0]};
      INST_LW:  return w;
      default:  return 32'h0;
    endcase
  endfunction

  // Behavioural dataMem: byte-addressed, little-endian, extension on loads, MEM_LAT pipeline.
  assign mem_rdata = pipe[MEM_LAT-1];
  initial begin
    logic [7:0]  idx;
    logic [1:0]  off;
    logic [31:0] w, nw;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'h0;
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = 32'h0;
    forever begin
      @(posedge clk);
      idx = mem_addr[9:2];
      off = mem_addr[1:0];
      w   = mem[idx];
      nw  = w;
      if (mem_inst == INST_SW) nw = mem_wdata;
      else if (mem_inst == INST_SH) nw[16*int'(off[1]) +: 16] = mem_wdata[15:0];
      else if (mem_inst == INST_SB) nw[8*int'(off) +: 8] = mem_wdata[7:0];
      mem[idx] <= nw;
      pipe[0]  <= load_val(mem_inst, w, off);
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: pops one expectation on the first cycle of each response.
  initial begin
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (mem_inst != 64'd0) begin
        issue_cnt++;
        last_inst = mem_inst;
        last_addr = mem_addr;
      end
      if (reset || rsp_valid == 2'b00) begin
        seen = 0;
      end else if (!seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_port", {62'd0, rsp_valid}, (e.port == 1) ? 64'd2 : 64'd1);
          check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
          check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          check("rsp_latency", 64'(cycle - e.acc), 64'(e.lat));
        end
      end
    end
  end

  task automatic send(input int p, input logic [63:0] inst, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic is_store);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    req_inst[p]  = inst;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    req_valid[p] = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) got = 1;
    end
    if (!got) begin
      check("req_timeout", {63'd0, req_ready[p]}, 64'd1);
      req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.port  = p;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = cycle;
    e.lat   = exp_err ? 1 : (is_store ? 2 : 2 + MEM_LAT);
    exp_q.push_back(e);
    grant_q.push_back(p);
  endtask

  task automatic wait_rsp();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rsp_valid == 2'b00) done = 1;
    end
    if (!done) check("rsp_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Single access on one port, also checking how many ISSUE cycles it produced.
  task automatic single(input string name, input int p, input logic [63:0] inst,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic is_store);
    int ic;
    ic = issue_cnt;
    send(p, inst, addr, wdata, exp_rdata, exp_err, is_store);
    req_valid[p] = 1'b0;
    wait_rsp();
    check({name, "_issues"}, 64'(issue_cnt - ic), exp_err ? 64'd0 : 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, {62'd0, req_ready}, 64'd0);
    check({name, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
    check({name, "_rsp_rdata"}, {32'd0, rsp_rdata}, 64'd0);
    check({name, "_rsp_err"},   {63'd0, rsp_err}, 64'd0);
    check({name, "_mem_inst"},  mem_inst, 64'd0);
    check({name, "_mem_addr"},  {32'd0, mem_addr}, 64'd0);
    check({name, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[8];
    int ic;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_inst  = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Port 0 store then load of the same word.
    single("t1_sw", 0, INST_SW, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    check("t1_sw_inst", last_inst, INST_SW);
    check("t1_sw_addr", {32'd0, last_addr}, 64'h8);
    single("t1_lw", 0, INST_LW, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    check("t1_lw_inst", last_inst, INST_LW);

    // Rejected accesses: never reach dataMem.
    single("t4_lh_odd",   0, INST_LH, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0);
    single("t4_sw_mis",   0, INST_SW, 32'h6, 32'h1234, 32'h0, 1'b1, 1'b1);
    single("t4_two_bits", 0, INST_LW | INST_SW, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    single("t4_other",    0, INST_LW | (64'd1 << 40), 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    single("t4_oob",      0, INST_LW, 32'(4 * MEM_SIZE), 32'h0, 32'h0, 1'b1, 1'b0);
    single("t4_last",     0, INST_LW, 32'(4 * (MEM_SIZE - 1)), 32'h0, 32'h0, 1'b0, 1'b0);

    // Port 1 sub-word stores/loads; extension comes from dataMem.
    single("t2_sw0", 1, INST_SW,  32'h0, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
    single("t2_sb",  1, INST_SB,  32'h4, 32'h000000AA, 32'h0, 1'b0, 1'b1);
    single("t2_lbu", 1, INST_LBU, 32'h4, 32'h0, 32'h000000AA, 1'b0, 1'b0);
    single("t2_lb",  1, INST_LB,  32'h4, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0);
    single("t2_sh",  1, INST_SH,  32'hE, 32'h00008001, 32'h0, 1'b0, 1'b1);
    single("t2_lhu", 1, INST_LHU, 32'hE, 32'h0, 32'h00008001, 1'b0, 1'b0);
    single("t2_lh",  1, INST_LH,  32'hE, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    single("t2_lw",  1, INST_LW,  32'hC, 32'h0, 32'h80010000, 1'b0, 1'b0);

    // Both ports continuously valid; port 1 was granted last.
    grant_q.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) send(0, INST_LW, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        req_valid[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) send(1, INST_LW, 32'h4, 32'h0, 32'h000000AA, 1'b0, 1'b0);
        req_valid[1] = 1'b0;
      end
    join
    wait_rsp();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    check("t3_grants", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_q.size(); k++)
      check($sformatf("t3_grant%0d", k), 64'(grant_q[k]), 64'(exp_order[k]));

    // Held response: stable outputs, no new grant until released.
    rsp_ready[0] = 1'b0;
    t5_done = 0;
    send(0, INST_LW, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid[0]; i++) @(negedge clk);
    fork
      begin
        send(1, INST_LW, 32'h4, 32'h0, 32'h000000AA, 1'b0, 1'b0);
        req_valid[1] = 1'b0;
        t5_done = 1;
      end
    join_none
    repeat (5) begin
      @(negedge clk);
      check("t5_hold_valid", {62'd0, rsp_valid}, 64'd1);
      check("t5_hold_rdata", {32'd0, rsp_rdata}, 64'hDEADBEEF);
      check("t5_hold_ready", {62'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_idle_ready", {62'd0, req_ready}, 64'd2);
    check("t5_idle_valid", {62'd0, rsp_valid}, 64'd0);
    for (int i = 0; i < 50 && !t5_done; i++) @(negedge clk);
    wait_rsp();
    check("t5_port1_done", {63'd0, t5_done}, 64'd1);

    // Reset during WAIT aborts the load; memory keeps its contents.
    single("t6_sw", 0, INST_SW, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b1);
    send(0, INST_LW, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    single("t6_lw", 0, INST_LW, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0);

    // Reset while a store is in CHECK: the store must never be committed.
    ic = issue_cnt;
    send(0, INST_SW, 32'h14, 32'hCAFEBABE, 32'h0, 1'b0, 1'b1);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_no_store_issue", 64'(issue_cnt - ic), 64'd0);
    single("t6_lw_old", 0, INST_LW, 32'h14, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
